// File: rtl/data_mem_ctrl.sv
// Data-memory responder: word-organised RAM serving one load/store at a time
// with WAIT_CYCLES wait states, a pipeline stall, and rejection of illegal requests.
module data_mem_ctrl #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        data_mem_re_in,
    input  logic        data_mem_we_in,
    input  logic [1:0]  data_mem_size_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    output logic [31:0] rdata_out,
    output logic        stall_out,
    output logic        error_out
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_RSVD = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic                  r_we;
    logic [1:0]            r_size;
    logic [ADDR_WIDTH+1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [31:0]           r_mem [0:(1<<ADDR_WIDTH)-1];

    logic                  w_idle;
    logic                  w_req;
    logic                  w_illegal;
    logic                  w_accept;
    logic                  w_reject;
    logic                  w_go_done;
    logic                  w_we;
    logic [1:0]            w_size;
    logic [ADDR_WIDTH+1:0] w_addr;
    logic [31:0]           w_wdata;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [31:0]           w_word;
    logic [31:0]           w_load;
    logic [3:0]            w_be;
    logic [31:0]           w_lanes;
    logic                  w_unused_addr;

    // Upper address bits are deliberately ignored so accesses wrap modulo RAM size.
    assign w_unused_addr = ^addr_in[31:ADDR_WIDTH+2];

    assign w_idle    = (r_state == S_IDLE);
    assign w_req     = data_mem_re_in | data_mem_we_in;
    assign w_illegal = (data_mem_re_in & data_mem_we_in)
                     | (data_mem_size_in == SZ_RSVD)
                     | ((data_mem_size_in == SZ_WORD) & (addr_in[1:0] != 2'b00))
                     | ((data_mem_size_in == SZ_HALF) & addr_in[0]);
    assign w_accept  = w_idle & w_req & ~w_illegal;
    assign w_reject  = w_idle & w_req & w_illegal;
    assign stall_out = w_accept | (r_state == S_WAIT);

    // With zero wait states the access completes on the acceptance edge, so the
    // operands come straight from the inputs while IDLE and from the latches otherwise.
    assign w_we      = w_idle ? data_mem_we_in : r_we;
    assign w_size    = w_idle ? data_mem_size_in : r_size;
    assign w_addr    = w_idle ? addr_in[ADDR_WIDTH+1:0] : r_addr;
    assign w_wdata   = w_idle ? wdata_in : r_wdata;
    assign w_idx     = w_addr[ADDR_WIDTH+1:2];
    assign w_word    = r_mem[w_idx];
    assign w_go_done = ((r_state == S_WAIT) && (r_cnt == 4'd1))
                     || (w_accept && (WAIT_CYCLES == 0));

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_be    = 4'b1111;
        w_lanes = w_wdata;
        w_load  = w_word;
        case (w_size)
            SZ_BYTE: begin
                w_be    = 4'b0001 << w_addr[1:0];
                w_lanes = {4{w_wdata[7:0]}};
                w_load  = {24'd0, w_word[{w_addr[1:0], 3'b000} +: 8]};
            end
            SZ_HALF: begin
                w_be    = w_addr[1] ? 4'b1100 : 4'b0011;
                w_lanes = {2{w_wdata[15:0]}};
                w_load  = {16'd0, (w_addr[1] ? w_word[31:16] : w_word[15:0])};
            end
            default: ;
        endcase
    end

    // NOTE: the RAM has no reset; a reset mid-access simply never reaches this write.
    always_ff @(posedge clk_in) begin
        if (w_go_done && w_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_lanes[8*i +: 8];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_we      <= 1'b0;
            r_size    <= SZ_BYTE;
            r_addr    <= '0;
            r_wdata   <= 32'd0;
            rdata_out <= 32'd0;
            error_out <= 1'b0;
        end else begin
            error_out <= w_reject;
            if (w_go_done && !w_we) rdata_out <= w_load;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we    <= data_mem_we_in;
                        r_size  <= data_mem_size_in;
                        r_addr  <= addr_in[ADDR_WIDTH+1:0];
                        r_wdata <= wdata_in;
                        if (WAIT_CYCLES == 0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= WAIT_LOAD;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd1) begin
                        r_state <= S_DONE;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Drives a 2-wait-state and a 0-wait-state controller with shared stimulus and
// compares both against a byte-addressed little-endian memory model.
module tb_data_mem_ctrl;

    localparam int D2 = 0;
    localparam int D0 = 1;

    logic        clk = 1'b0;
    logic        rst_n2, rst_n0;
    logic        re, we;
    logic [1:0]  sz;
    logic [31:0] addr, wd;
    logic [31:0] rdata2, rdata0;
    logic        stall2, stall0, err2, err0;

    logic [7:0]  mb [2][4096];
    logic [31:0] exp_rd [2];
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut_w2 (
        .clk_in(clk), .rst_n_in(rst_n2), .data_mem_re_in(re), .data_mem_we_in(we),
        .data_mem_size_in(sz), .addr_in(addr), .wdata_in(wd),
        .rdata_out(rdata2), .stall_out(stall2), .error_out(err2)
    );

    data_mem_ctrl #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut_w0 (
        .clk_in(clk), .rst_n_in(rst_n0), .data_mem_re_in(re), .data_mem_we_in(we),
        .data_mem_size_in(sz), .addr_in(addr), .wdata_in(wd),
        .rdata_out(rdata0), .stall_out(stall0), .error_out(err0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic bit legal(input logic r, input logic w, input logic [1:0] s,
                                 input logic [31:0] a);
        if (r && w) return 1'b0;
        if (s == 2'b10) return 1'b0;
        if (s == 2'b11 && a[1:0] != 2'b00) return 1'b0;
        if (s == 2'b01 && a[0]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] mload(input int d, input logic [1:0] s, input logic [31:0] a);
        logic [31:0] v = 32'd0;
        int base = int'(a[11:0]);
        for (int k = 0; k < nbytes(s); k++) v = v | (32'(mb[d][base + k]) << (8 * k));
        return v;
    endfunction

    task automatic mstore(input int d, input logic [1:0] s, input logic [31:0] a, input logic [31:0] w);
        int base = int'(a[11:0]);
        for (int k = 0; k < nbytes(s); k++) mb[d][base + k] = 8'(w >> (8 * k));
    endtask

    // One request, held for its acceptance cycle only, then four cycles observed.
    task automatic txn(input logic i_re, input logic i_we, input logic [1:0] i_sz,
                       input logic [31:0] i_a, input logic [31:0] i_wd);
        bit ok = legal(i_re, i_we, i_sz, i_a);
        re = i_re; we = i_we; sz = i_sz; addr = i_a; wd = i_wd;
        @(negedge clk);
        check("c0_stall_w2", 32'(stall2), 32'(ok));
        check("c0_stall_w0", 32'(stall0), 32'(ok));
        check("c0_err_w2", 32'(err2), 32'd0);
        @(posedge clk); #1;
        re = 1'b0; we = 1'b0;
        if (ok) begin
            if (i_we) begin
                mstore(D2, i_sz, i_a, i_wd);
                mstore(D0, i_sz, i_a, i_wd);
            end else begin
                exp_rd[D2] = mload(D2, i_sz, i_a);
                exp_rd[D0] = mload(D0, i_sz, i_a);
            end
        end
        @(negedge clk);
        check("c1_stall_w2", 32'(stall2), 32'(ok));
        check("c1_stall_w0", 32'(stall0), 32'd0);
        check("c1_err_w2", 32'(err2), 32'(!ok));
        check("c1_err_w0", 32'(err0), 32'(!ok));
        check("c1_rdata_w0", rdata0, exp_rd[D0]);
        @(negedge clk);
        check("c2_stall_w2", 32'(stall2), 32'(ok));
        check("c2_err_w2", 32'(err2), 32'd0);
        @(negedge clk);
        check("c3_stall_w2", 32'(stall2), 32'd0);
        check("c3_rdata_w2", rdata2, exp_rd[D2]);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] old40;
        logic [31:0] exp10;
        rst_n2 = 1'b0; rst_n0 = 1'b0;
        re = 1'b0; we = 1'b0; sz = 2'b00; addr = 32'd0; wd = 32'd0;
        exp_rd[D2] = 32'd0; exp_rd[D0] = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_rdata_w2", rdata2, 32'd0);
        check("rst_stall_w2", 32'(stall2), 32'd0);
        check("rst_err_w2", 32'(err2), 32'd0);
        check("rst_rdata_w0", rdata0, 32'd0);
        rst_n2 = 1'b1; rst_n0 = 1'b1;
        @(posedge clk); #1;

        for (int w = 0; w < 32; w++) txn(1'b0, 1'b1, 2'b11, 32'(w * 4), $urandom);

        txn(1'b0, 1'b1, 2'b11, 32'h10, 32'hDEADBEEF);
        txn(1'b1, 1'b0, 2'b11, 32'h10, 32'd0);
        check("p1_word", rdata2, 32'hDEADBEEF);

        txn(1'b0, 1'b1, 2'b11, 32'h20, 32'h0);
        txn(1'b0, 1'b1, 2'b00, 32'h22, 32'hFFFF_FFA5);
        txn(1'b1, 1'b0, 2'b11, 32'h20, 32'd0);
        check("p2_word", rdata2, 32'h00A50000);
        txn(1'b1, 1'b0, 2'b00, 32'h22, 32'd0);
        check("p2_byte", rdata2, 32'h000000A5);
        txn(1'b1, 1'b0, 2'b01, 32'h22, 32'd0);
        check("p2_half", rdata2, 32'h000000A5);

        txn(1'b0, 1'b1, 2'b11, 32'h30, 32'h8001FFFF);
        txn(1'b1, 1'b0, 2'b01, 32'h32, 32'd0);
        check("p3_half_zext", rdata2, 32'h00008001);

        txn(1'b1, 1'b0, 2'b11, 32'h06, 32'd0);
        txn(1'b1, 1'b0, 2'b01, 32'h03, 32'd0);
        txn(1'b1, 1'b0, 2'b10, 32'h00, 32'd0);
        txn(1'b1, 1'b1, 2'b11, 32'h00, 32'h5555_5555);
        check("p4_rdata_hold_w2", rdata2, 32'h00008001);
        check("p4_rdata_hold_w0", rdata0, 32'h00008001);

        // Reset the 2-wait-state controller in its first WAIT cycle of a store.
        txn(1'b0, 1'b1, 2'b11, 32'h40, 32'hCAFEF00D);
        old40 = mload(D2, 2'b11, 32'h40);
        re = 1'b0; we = 1'b1; sz = 2'b11; addr = 32'h40; wd = 32'h12345678;
        @(negedge clk);
        check("p5_accept_stall", 32'(stall2), 32'd1);
        @(posedge clk); #1;
        we = 1'b0;
        mstore(D0, 2'b11, 32'h40, 32'h12345678);
        #2 rst_n2 = 1'b0;
        #1;
        check("p5_rst_stall", 32'(stall2), 32'd0);
        check("p5_rst_rdata", rdata2, 32'd0);
        exp_rd[D2] = 32'd0;
        @(posedge clk);
        @(negedge clk) rst_n2 = 1'b1;
        @(posedge clk); #1;
        txn(1'b1, 1'b0, 2'b11, 32'h40, 32'd0);
        check("p5_no_commit", rdata2, old40);
        check("p5_w0_commit", rdata0, 32'h12345678);

        // Continuously held load on the zero-wait controller, via an aliased address.
        exp10 = mload(D0, 2'b11, 32'h10);
        re = 1'b1; we = 1'b0; sz = 2'b11; addr = 32'h1010;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("p6_stall_k%0d", k), 32'(stall0), 32'((k % 2) == 0));
            if (k % 2 == 1) check($sformatf("p6_alias_k%0d", k), rdata0, 32'hDEADBEEF);
            @(posedge clk);
        end
        #1 re = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        exp_rd[D2] = mload(D2, 2'b11, 32'h10);
        exp_rd[D0] = exp10;
        check("p6_w2_rdata", rdata2, exp_rd[D2]);

        for (int n = 0; n < 80; n++) begin
            logic        r_re, r_we;
            logic [1:0]  r_sz;
            logic [31:0] r_a;
            r_a = $urandom;
            r_a[11:7] = 5'd0;
            if ($urandom_range(0, 9) == 0) begin
                r_re = 1'($urandom);
                r_we = r_re ? 1'($urandom) : 1'b1;
                r_sz = 2'($urandom);
            end else begin
                r_re = 1'($urandom);
                r_we = !r_re;
                case ($urandom_range(0, 2))
                    0:       r_sz = 2'b00;
                    1:       begin r_sz = 2'b01; r_a[0] = 1'b0; end
                    default: begin r_sz = 2'b11; r_a[1:0] = 2'b00; end
                endcase
            end
            txn(r_re, r_we, r_sz, r_a, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
